// File: rtl/fetch_stage_if.sv
// fetch_stage_if: ID-stage redirect controls, i_mem port and IF/ID outputs of the fetch stage
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] i_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;
    modport master (
        output stall, branch_taken, branch_offset, jump, jump_index, jr, jr_target, i_data,
        input  pc, if_id_instr, if_id_pc4, if_id_valid, misalign_err, fetch_count
    );
    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_index, jr, jr_target, i_data,
        output pc, if_id_instr, if_id_pc4, if_id_valid, misalign_err, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register with stall, flush and redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic         clk,
    input logic         reset,
    fetch_stage_if.slave bus
);
    logic        redirect;
    logic [31:0] target;
    always_comb begin
        redirect = bus.jr | bus.jump | bus.branch_taken;
        target   = bus.jr   ? bus.jr_target :
                   bus.jump ? {bus.if_id_pc4[31:28], bus.jump_index, 2'b00} :
                              bus.if_id_pc4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc           <= RESET_PC;
            bus.if_id_instr  <= NOP_INSTR;
            bus.if_id_pc4    <= '0;
            bus.if_id_valid  <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.fetch_count  <= '0;
        end else if (redirect) begin
            bus.pc          <= {target[31:2], 2'b00};
            bus.if_id_instr <= NOP_INSTR;
            bus.if_id_valid <= 1'b0;
            if (target[1:0] != 2'b00) bus.misalign_err <= 1'b1;
        end else if (!bus.stall) begin
            bus.pc          <= bus.pc + 32'd4;
            bus.if_id_instr <= bus.i_data;
            bus.if_id_pc4   <= bus.pc + 32'd4;
            bus.if_id_valid <= 1'b1;
            bus.fetch_count <= bus.fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with a per-cycle expected-state scoreboard for fetch_stage
module tb_fetch_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        merr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem [1024];
    exp_t        q [$];
    exp_t        e;
    int          checks = 0;
    int          passed = 0;

    fetch_stage_if bus ();
    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.i_data = mem[bus.pc[11:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("if_id_instr", bus.if_id_instr, e.instr);
            chk("if_id_pc4", bus.if_id_pc4, e.pc4);
            chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
            chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e.merr});
            chk("fetch_count", bus.fetch_count, e.cnt);
        end
    end

    task automatic drv(input logic r, input logic s, input logic b, input logic [15:0] off,
                       input logic j, input logic [25:0] idx, input logic jrv, input logic [31:0] jt);
        reset             = r;
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.branch_offset = off;
        bus.jump          = j;
        bus.jump_index    = idx;
        bus.jr            = jrv;
        bus.jr_target     = jt;
    endtask

    task automatic cyc(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] p4,
                       input logic v, input logic m, input logic [31:0] c);
        exp_t x;
        @(posedge clk);
        #1;
        x = '{p, ins, p4, v, m, c};
        q.push_back(x);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = k + 1;
        drv(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h0, 32'h0, 32'h0, 0, 0, 0);
        cyc(32'h0, 32'h0, 32'h0, 0, 0, 0);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h4, 32'h1, 32'h4, 1, 0, 1);
        cyc(32'h8, 32'h2, 32'h8, 1, 0, 2);
        drv(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h8, 32'h2, 32'h8, 1, 0, 2);
        cyc(32'h8, 32'h2, 32'h8, 1, 0, 2);
        cyc(32'h8, 32'h2, 32'h8, 1, 0, 2);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'hC, 32'h3, 32'hC, 1, 0, 3);
        cyc(32'h10, 32'h4, 32'h10, 1, 0, 4);
        drv(0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        cyc(32'h8, 32'h0, 32'h10, 0, 0, 4);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'hC, 32'h3, 32'hC, 1, 0, 5);
        drv(0, 0, 1, 16'h0100, 1, 26'h2AA, 1, 32'h40);
        cyc(32'h40, 32'h0, 32'hC, 0, 0, 5);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h8000_0000);
        cyc(32'h8000_0000, 32'h0, 32'hC, 0, 0, 5);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h8000_0004, 32'h1, 32'h8000_0004, 1, 0, 6);
        drv(0, 0, 0, 16'h0, 1, 26'h10, 0, 32'h0);
        cyc(32'h8000_0040, 32'h0, 32'h8000_0004, 0, 0, 6);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h8000_0044, 32'h11, 32'h8000_0044, 1, 0, 7);
        drv(0, 0, 1, 16'h0001, 1, 26'h3, 0, 32'h0);
        cyc(32'h8000_000C, 32'h0, 32'h8000_0044, 0, 0, 7);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0022);
        cyc(32'h20, 32'h0, 32'h8000_0044, 0, 1, 7);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h24, 32'h9, 32'h24, 1, 1, 8);
        cyc(32'h28, 32'hA, 32'h28, 1, 1, 9);
        drv(0, 1, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC);
        cyc(32'hFFFF_FFFC, 32'h0, 32'h28, 0, 1, 9);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h0, 32'h400, 32'h0, 1, 1, 10);
        drv(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h0, 32'h400, 32'h0, 1, 1, 10);
        drv(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h0, 32'h0, 32'h0, 0, 0, 0);
        drv(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        cyc(32'h4, 32'h1, 32'h4, 1, 0, 1);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
